// File: rtl/mult_arbiter.sv
// mult_arbiter: shares a single multiplier among NUM_REQ requesters.
// The arbiter captures the winner's operands and runs the multiplier
// start/acknowledge handshake. It then returns the result to the owning
// requester over a valid/ack handshake. Only one operation is in flight
// at a time.
//
// Build option: define MULT_ARB_FIXED_PRIO_EN to select fixed priority,
// where the lowest index wins and there is no pointer register. Without
// it (the default) the arbiter is round-robin.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        iReq,
    input  logic [NUM_REQ*DATA_W-1:0] iData_A_Bus,
    input  logic [NUM_REQ*DATA_W-1:0] iData_B_Bus,
    output logic [NUM_REQ-1:0]        oGrant,
    output logic [NUM_REQ-1:0]        oResultValid,
    input  logic [NUM_REQ-1:0]        iResultAck,
    output logic [DATA_W-1:0]         oResult,
    output logic                      oBusy,
    output logic [DATA_W-1:0]         oMul_A,
    output logic [DATA_W-1:0]         oMul_B,
    output logic                      oMul_Valid,
    output logic                      oMul_Ack,
    input  logic                      iMul_Done,
    input  logic                      iMul_Idle,
    input  logic [DATA_W-1:0]         iMul_Result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Sequencer states.
    localparam logic [2:0] ARB_IDLE   = 3'd0;
    localparam logic [2:0] ARB_ISSUE  = 3'd1;
    localparam logic [2:0] ARB_WAIT   = 3'd2;
    localparam logic [2:0] ARB_RETURN = 3'd3;
    localparam logic [2:0] ARB_ACK    = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic             winner_found;

    // The flat operand buses are unpacked into per-requester lanes, so
    // the winner's operands are chosen with a plain array index.
    logic [DATA_W-1:0] lane_a [NUM_REQ];
    logic [DATA_W-1:0] lane_b [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign lane_a[k] = iData_A_Bus[k*DATA_W +: DATA_W];
        assign lane_b[k] = iData_B_Bus[k*DATA_W +: DATA_W];
    end

`ifdef MULT_ARB_FIXED_PRIO_EN

    // Fixed priority: pick the lowest-indexed active request.
    always_comb begin : winner_search
        // NOTE: every signal this block writes gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        winner       = '0;
        winner_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!winner_found && iReq[i]) begin
                winner       = IDX_W'(i);
                winner_found = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr;

    // Round-robin: search upward from the pointer and wrap past the
    // last requester. Only request bits high in this cycle take part.
    always_comb begin : winner_search
        // NOTE: every signal this block writes gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        logic [IDX_W:0] idx;
        idx          = '0;
        winner       = '0;
        winner_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!winner_found && iReq[idx[IDX_W-1:0]]) begin
                winner       = idx[IDX_W-1:0];
                winner_found = 1'b1;
            end
        end
    end

    // The pointer moves just past the requester that was granted. A
    // requester that is still requesting therefore waits for its next turn.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr <= '0;
        end else if (state == ARB_IDLE && iMul_Idle && winner_found) begin
            ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

`endif

    // Sequencer: capture operands, hand them to the multiplier, wait for
    // the product, return it to the owner, then release the multiplier.
    always_ff @(posedge Clock) begin
        // NOTE: registers are updated with non-blocking assignments, so
        // every right-hand side reads the value from before this edge.
        if (Reset) begin
            // NOTE: the datapath registers are reset as well as the control
            // registers, because they drive outputs that must read zero
            // after reset.
            state   <= ARB_IDLE;
            owner   <= '0;
            oResult <= '0;
            oMul_A  <= '0;
            oMul_B  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // A busy multiplier blocks any grant, even when
                    // requests are pending.
                    if (iMul_Idle && winner_found) begin
                        oMul_A <= lane_a[winner];
                        oMul_B <= lane_b[winner];
                        owner  <= winner;
                        state  <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    // There is no timeout: the multiplier must finish.
                    if (iMul_Done) begin
                        oResult <= iMul_Result;
                        state   <= ARB_RETURN;
                    end
                end
                ARB_RETURN: begin
                    // Acks from requesters other than the owner are ignored.
                    if (iResultAck[owner]) begin
                        state <= ARB_ACK;
                    end
                end
                ARB_ACK: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state and the owner. This
    // keeps at most one grant bit and one valid bit high in any cycle.
    always_comb begin
        oGrant       = '0;
        oResultValid = '0;
        if (state == ARB_ISSUE) begin
            oGrant[owner] = 1'b1;
        end
        if (state == ARB_RETURN) begin
            oResultValid[owner] = 1'b1;
        end
        oMul_Valid = (state == ARB_ISSUE);
        oMul_Ack   = (state == ARB_ACK);
        oBusy      = (state != ARB_IDLE);
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter. The bench contains a behavioural
// multiplier model with a fixed latency. It also keeps a reference model
// that predicts the winner of each arbitration from the request vector.
// Define MULT_ARB_FIXED_PRIO_EN when compiling to check the fixed-priority
// build.
module tb_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int LAT     = 33;

    logic                      Clock;
    logic                      Reset;
    logic [NUM_REQ-1:0]        iReq;
    logic [NUM_REQ*DATA_W-1:0] iData_A_Bus;
    logic [NUM_REQ*DATA_W-1:0] iData_B_Bus;
    logic [NUM_REQ-1:0]        oGrant;
    logic [NUM_REQ-1:0]        oResultValid;
    logic [NUM_REQ-1:0]        iResultAck;
    logic [DATA_W-1:0]         oResult;
    logic                      oBusy;
    logic [DATA_W-1:0]         oMul_A;
    logic [DATA_W-1:0]         oMul_B;
    logic                      oMul_Valid;
    logic                      oMul_Ack;
    logic                      iMul_Done;
    logic                      iMul_Idle;
    logic [DATA_W-1:0]         iMul_Result;

    mult_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iReq         (iReq),
        .iData_A_Bus  (iData_A_Bus),
        .iData_B_Bus  (iData_B_Bus),
        .oGrant       (oGrant),
        .oResultValid (oResultValid),
        .iResultAck   (iResultAck),
        .oResult      (oResult),
        .oBusy        (oBusy),
        .oMul_A       (oMul_A),
        .oMul_B       (oMul_B),
        .oMul_Valid   (oMul_Valid),
        .oMul_Ack     (oMul_Ack),
        .iMul_Done    (iMul_Done),
        .iMul_Idle    (iMul_Idle),
        .iMul_Result  (iMul_Result)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Multiplier model: IDLE -> BUSY for LAT cycles -> DONE until acked.
    int          mul_state;
    int          mul_cnt;
    logic [31:0] mul_res;
    bit          idle_force;

    always @(posedge Clock) begin
        if (Reset) begin
            mul_state <= 0;
            mul_cnt   <= 0;
            mul_res   <= '0;
        end else begin
            case (mul_state)
                0: if (oMul_Valid) begin
                    mul_state <= 1;
                    mul_cnt   <= LAT - 1;
                    mul_res   <= oMul_A * oMul_B;
                end
                1: if (mul_cnt == 0) mul_state <= 2;
                   else mul_cnt <= mul_cnt - 1;
                default: if (oMul_Ack) mul_state <= 0;
            endcase
        end
    end

    assign iMul_Done   = (mul_state == 2);
    assign iMul_Idle   = (mul_state == 0) && !idle_force;
    assign iMul_Result = (mul_state == 2) ? mul_res : 32'hDEAD_BEEF;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arbitration rule.
    function automatic int pick(input logic [NUM_REQ-1:0] req);
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            int j = i;
`else
            int j = (model_ptr + i) % NUM_REQ;
`endif
            if (req[j]) return j;
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},  32'(oGrant),       0);
        check({tag, "_valid"},  32'(oResultValid), 0);
        check({tag, "_result"}, oResult,           0);
        check({tag, "_busy"},   32'(oBusy),        0);
        check({tag, "_mul_a"},  oMul_A,            0);
        check({tag, "_mul_b"},  oMul_B,            0);
        check({tag, "_mvalid"}, 32'(oMul_Valid),   0);
        check({tag, "_mack"},   32'(oMul_Ack),     0);
    endtask

    // One complete transaction, started from ARB_IDLE at a negedge.
    task automatic do_round(input logic [NUM_REQ-1:0] req, input logic [NUM_REQ-1:0] wrong_ack,
                            input int idle_block, input bit directed,
                            input logic [31:0] da, input logic [31:0] db);
        logic [31:0] a [NUM_REQ];
        logic [31:0] b [NUM_REQ];
        logic [31:0] ea, eb, prod;
        logic [NUM_REQ-1:0] onehot;
        int w;
        bit seen;
        for (int k = 0; k < NUM_REQ; k++) begin
            a[k] = $urandom;
            b[k] = $urandom;
        end
        w = pick(req);
        if (directed) begin
            a[w] = da;
            b[w] = db;
        end
        onehot = NUM_REQ'(1 << w);
        iData_A_Bus = {a[3], a[2], a[1], a[0]};
        iData_B_Bus = {b[3], b[2], b[1], b[0]};
        iReq = req;
        if (idle_block > 0) begin
            idle_force = 1'b1;
            repeat (idle_block) begin
                @(negedge Clock);
                check("grant_while_mul_busy", 32'(oGrant), 0);
                check("busy_while_mul_busy", 32'(oBusy), 0);
            end
            idle_force = 1'b0;
        end
        @(negedge Clock);
        check("grant", 32'(oGrant), 32'(onehot));
        check("mul_valid", 32'(oMul_Valid), 1);
        check("busy_issue", 32'(oBusy), 1);
        check("mul_a", oMul_A, a[w]);
        check("mul_b", oMul_B, b[w]);
        ea = a[w];
        eb = b[w];
        prod = ea * eb;
        model_ptr = (w + 1) % NUM_REQ;
        // Operands may change from the cycle after the grant.
        iData_A_Bus = {$urandom, $urandom, $urandom, $urandom};
        iData_B_Bus = {$urandom, $urandom, $urandom, $urandom};
        seen = 1'b0;
        for (int c = 0; c < LAT + 10 && !seen; c++) begin
            @(negedge Clock);
            if (oResultValid != '0) seen = 1'b1;
            else check("grant_quiet", 32'(oGrant), 0);
        end
        check("result_wait_timeout", 32'(seen), 1);
        check("result_valid", 32'(oResultValid), 32'(onehot));
        check("result", oResult, prod);
        check("mul_a_stable", oMul_A, ea);
        check("mul_b_stable", oMul_B, eb);
        if ((wrong_ack & ~onehot) != '0) begin
            iResultAck = wrong_ack & ~onehot;
            repeat (3) begin
                @(negedge Clock);
                check("valid_held", 32'(oResultValid), 32'(onehot));
                check("result_held", oResult, prod);
            end
        end
        iResultAck = onehot;
        @(negedge Clock);
        check("valid_cleared", 32'(oResultValid), 0);
        check("mul_ack", 32'(oMul_Ack), 1);
        check("busy_ack", 32'(oBusy), 1);
        iResultAck = '0;
        @(negedge Clock);
        check("mul_ack_pulse", 32'(oMul_Ack), 0);
        check("busy_idle", 32'(oBusy), 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        iReq = '0;
        iResultAck = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        model_ptr = 0;
    endtask

    // At most one grant bit and one valid bit may be high in any cycle.
    always @(negedge Clock) begin
        check("grant_onehot", 32'($countones(oGrant) <= 1), 1);
        check("valid_onehot", 32'($countones(oResultValid) <= 1), 1);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_force  = 1'b0;
        Reset       = 1'b1;
        iReq        = '0;
        iResultAck  = '0;
        iData_A_Bus = '0;
        iData_B_Bus = '0;
        repeat (3) @(negedge Clock);
        check_all_zero("in_reset");
        Reset = 1'b0;
        @(negedge Clock);
        check_all_zero("after_reset");

        // Directed 7 * 6 on requester 0.
        do_round(4'b0001, 4'b0000, 0, 1'b1, 32'd7, 32'd6);

        // All requesting, immediate acks: rotation from pointer 0.
        do_reset();
        for (int r = 0; r < 5; r++) do_round(4'b1111, 4'b0000, 0, 1'b0, 0, 0);

        // A foreign ack while requester 0 owns the result is ignored.
        do_round(4'b0001, 4'b0100, 0, 1'b0, 0, 0);

        // A busy multiplier holds off the grant.
        do_round(4'b0010, 4'b0000, 3, 1'b0, 0, 0);

        // Randomized traffic.
        for (int r = 0; r < 24; r++) begin
            logic [NUM_REQ-1:0] rq;
            rq = NUM_REQ'($urandom_range(1, 15));
            do_round(rq, NUM_REQ'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0,
                     1'b0, 0, 0);
        end

        // Reset in ARB_WAIT aborts; the pointer restarts at 0.
        iReq = 4'b0100;
        iData_A_Bus = {$urandom, $urandom, $urandom, $urandom};
        iData_B_Bus = {$urandom, $urandom, $urandom, $urandom};
        @(negedge Clock);
        check("pre_abort_grant", 32'(oGrant), 32'h4);
        iReq = '0;
        repeat (5) @(negedge Clock);
        check("pre_abort_busy", 32'(oBusy), 1);
        Reset = 1'b1;
        @(negedge Clock);
        check_all_zero("abort");
        Reset = 1'b0;
        model_ptr = 0;
        do_round(4'b1010, 4'b0000, 0, 1'b0, 0, 0);
        iReq = '0;
        repeat (4) @(negedge Clock);
        check("final_idle", 32'(oBusy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one Multiplicator instance among NUM_REQ requesters.
- Captures the winning requester's operands and drives the multiplier start/acknowledge handshake.
- Returns the 32-bit result to the owning requester over a valid/ack handshake.
- Sits between the client blocks and the multiplier; the multiplier is never driven by more than one client.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand and result width; must equal the multiplier width

Ports:
Clock  in  1  system clock, all logic on posedge
Reset  in  1  synchronous, active-high reset
iReq  in  NUM_REQ  request bit per requester, level
iData_A_Bus  in  NUM_REQ*DATA_W  operand A of requester k at bits [k*DATA_W +: DATA_W]
iData_B_Bus  in  NUM_REQ*DATA_W  operand B, same packing
oGrant  out  NUM_REQ  one-cycle pulse: operands of requester k captured
oResultValid  out  NUM_REQ  result for requester k present on oResult, held until acked
iResultAck  in  NUM_REQ  result accepted by requester k
oResult  out  DATA_W  registered result of the current owner
oBusy  out  1  high whenever state != ARB_IDLE
oMul_A  out  DATA_W  registered operand A to the multiplier
oMul_B  out  DATA_W  registered operand B to the multiplier
oMul_Valid  out  1  to multiplier iValid_Data
oMul_Ack  out  1  to multiplier iAcknoledged
iMul_Done  in  1  from multiplier oDone
iMul_Idle  in  1  from multiplier oIdle
iMul_Result  in  DATA_W  from multiplier oResult

Behaviour:
- Reset values:
  - state = ARB_IDLE; round-robin pointer = 0; owner = 0.
  - All outputs 0: oGrant, oResultValid, oResult, oBusy, oMul_A, oMul_B, oMul_Valid, oMul_Ack.
- Reset mid-operation: the arbiter aborts to ARB_IDLE. Any pending result is dropped with no grant or valid. The multiplier is reset by the same Reset.
- States: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RETURN, ARB_ACK. Registered state; outputs are registered or pure decodes of state.
- ARB_IDLE:
  - When iMul_Idle=1 and |iReq: choose the winner as the first set iReq bit searching upward from the pointer, wrapping at NUM_REQ-1 -> 0.
  - Latch the winner's operands into oMul_A/oMul_B, record owner, set pointer = (winner+1) mod NUM_REQ, go ARB_ISSUE.
  - Otherwise stay in ARB_IDLE.
  - If iMul_Idle=0, no grant is issued even if requests are pending.
- ARB_ISSUE (exactly 1 cycle): oGrant[owner]=1 and oMul_Valid=1, then go ARB_WAIT. Requester k may drop iReq or change its operands from the cycle after the oGrant pulse.
- ARB_WAIT:
  - oMul_A/oMul_B stay stable.
  - On iMul_Done=1: capture iMul_Result into oResult, set oResultValid[owner]=1 (visible the next cycle), go ARB_RETURN.
  - There is no timeout.
- ARB_RETURN:
  - oResultValid[owner] and oResult are held stable.
  - iResultAck bits other than owner are ignored.
  - On iResultAck[owner]=1: clear oResultValid, go ARB_ACK.
- ARB_ACK (exactly 1 cycle): oMul_Ack=1. The multiplier leaves DONE on the same edge the arbiter enters ARB_IDLE, so iMul_Idle is high on the first ARB_IDLE cycle.
- Throughput: at most one operation in flight.
  - Back-to-back grants are separated by the multiplier latency plus 4 arbiter cycles.
  - Latency from request to grant is 1 cycle when idle.
- Simultaneous events:
  - A request arriving in ARB_IDLE on the same cycle another requester's request drops: only bits high in that cycle are considered.
  - A requester whose iReq is still high after its own completion takes its next round-robin turn; it is not re-served ahead of others.
- Width: operands and result are DATA_W bits, passed unchanged. Truncation of the product is the multiplier's.
- At most one bit of oGrant and one bit of oResultValid is high in any cycle.

Optional Feature:
Macro MULT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer register is removed.
- Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then iReq=4'b0001 with A=7, B=6 and a model multiplier (done after 33 cycles) -> oGrant=0001 pulse 1 cycle after the request; oResult=42 with oResultValid=0001 until ack; oMul_Ack pulses once.
- iReq=4'b1111 held, each client acks immediately -> grants in order 0,1,2,3,0; no requester served twice in a row.
- Same stimulus with MULT_ARB_FIXED_PRIO_EN -> requester 0 granted every round.
- iResultAck=4'b0100 while the owner is 0 -> ignored; oResultValid=0001 held with oResult unchanged until iResultAck[0].
- iMul_Idle forced 0 with iReq=0010 -> no grant until iMul_Idle=1; grant follows 1 cycle later.
- Reset asserted in ARB_WAIT -> next cycle all outputs 0 and state ARB_IDLE; a new request afterwards is served starting from pointer 0.
